win_detector: RTL

//   Produces the player1_win / player2_win pulses consumed by the game-over latch stage.
//   On a start request it snapshots the 3x3 board and scans the 8 winning lines over

---
 rtl/win_detector.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/win_detector.sv
// Tic-tac-toe win detector: snapshots a 3x3 board on start, scans the 8 winning
// lines LINES_PER_CYCLE at a time, then pulses a one-cycle win/draw/error report.
module win_detector #(
  parameter int LINES_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [17:0] board,
  output logic        busy,
  output logic        done,
  output logic        player1_win,
  output logic        player2_win,
  output logic        draw,
  output logic        error,
  output logic [1:0]  winner,
  output logic [1:0]  dbg_state
);

  generate
    if (LINES_PER_CYCLE != 1 && LINES_PER_CYCLE != 2 &&
        LINES_PER_CYCLE != 4 && LINES_PER_CYCLE != 8) begin : g_bad_lpc
      $error("win_detector: LINES_PER_CYCLE must be 1, 2, 4 or 8");
    end
  endgenerate

  // Handshake: start is a level sampled only in IDLE; a request seen while busy
  // is dropped, never queued. done qualifies the result pulses for one cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, REPORT = 2'd2} state_e;

  state_e      state_q;
  logic [17:0] snap_q;
  logic [2:0]  idx_q;
  logic        p1_q, p2_q;
  logic        p1_d, p2_d;
  logic        p1_hit, p2_hit;
  logic        all_full;
  logic        last_scan;

  // Cell indices of each winning line, packed as {c0, c1, c2}.
  function automatic logic [11:0] line_cells(input logic [2:0] l);
    case (l)
      3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
      3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
      3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
      3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
      3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
      3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
      3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
      default: line_cells = {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  always_comb begin
    logic [2:0]  l;
    logic [11:0] cells;
    logic [1:0]  a, b, c;
    p1_hit = 1'b0;
    p2_hit = 1'b0;
    l      = '0;
    cells  = '0;
    a      = '0;
    b      = '0;
    c      = '0;
    for (int k = 0; k < LINES_PER_CYCLE; k++) begin
      l     = idx_q + 3'(k);
      cells = line_cells(l);
      a     = snap_q[{cells[11:8], 1'b0} +: 2];
      b     = snap_q[{cells[7:4], 1'b0} +: 2];
      c     = snap_q[{cells[3:0], 1'b0} +: 2];
      if (a == 2'b01 && b == 2'b01 && c == 2'b01) p1_hit = 1'b1;
      if (a == 2'b10 && b == 2'b10 && c == 2'b10) p2_hit = 1'b1;
    end
  end

  // Code 11 counts as an empty cell for the draw decision.
  always_comb begin
    all_full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (snap_q[2*i +: 2] == 2'b00 || snap_q[2*i +: 2] == 2'b11) all_full = 1'b0;
    end
  end

  assign p1_d      = p1_q | p1_hit;
  assign p2_d      = p2_q | p2_hit;
  assign last_scan = (idx_q == 3'(8 - LINES_PER_CYCLE));
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      idx_q       <= '0;
      p1_q        <= 1'b0;
      p2_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      player1_win <= 1'b0;
      player2_win <= 1'b0;
      draw        <= 1'b0;
      error       <= 1'b0;
      winner      <= 2'b00;
    end else begin
      done        <= 1'b0;
      player1_win <= 1'b0;
      player2_win <= 1'b0;
      draw        <= 1'b0;
      error       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            snap_q  <= board;
            p1_q    <= 1'b0;
            p2_q    <= 1'b0;
            idx_q   <= '0;
            winner  <= 2'b00;
            busy    <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          p1_q  <= p1_d;
          p2_q  <= p2_d;
          idx_q <= idx_q + 3'(LINES_PER_CYCLE);
          // Result pulses are registered together with the move into REPORT.
          if (last_scan) begin
            state_q     <= REPORT;
            done        <= 1'b1;
            player1_win <= p1_d & ~p2_d;
            player2_win <= p2_d & ~p1_d;
            error       <= p1_d & p2_d;
            draw        <= ~p1_d & ~p2_d & all_full;
            winner      <= {p2_d, p1_d};
          end
        end
        REPORT: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
